// File: rtl/johnson_phase_sched_pkg.sv
// johnson_phase_sched_pkg
//   Shared types and helpers for the Johnson phase scheduler.
//   - state_t      : scheduler FSM states (IDLE, RUN, DONE)
//   - johnson_next : one Johnson step {~q[0], q[W-1:1]} for widths up to 32
package johnson_phase_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operates on a 32-bit container so one function serves every WIDTH;
  // bits at and above 'width' in 'cur' are expected to be zero.
  function automatic logic [31:0] johnson_next(input logic [31:0] cur,
                                               input int unsigned width);
    logic [31:0] mask;
    logic [31:0] msb;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    msb  = {31'd0, ~cur[0]} << (width - 1);
    return ((cur >> 1) | msb) & mask;
  endfunction

endpackage

// File: rtl/johnson_phase_sched_if.sv
// johnson_phase_sched_if
//   Request/grant/phase bundle between requesters (master) and the
//   scheduler (slave).
//   req[NREQ], len[NREQ*LEN_W]        : requester -> scheduler
//   grant, phase, phase_valid, busy,
//   done, done_id, aborted            : scheduler -> requester
//   Optional: JOHNSON_PHASE_SCHED_HOLD_EN adds 'hold' (requester -> scheduler).
interface johnson_phase_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 8
);
  localparam int unsigned ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] len;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      phase;
  logic                  phase_valid;
  logic                  busy;
  logic                  done;
  logic [ID_W-1:0]       done_id;
  logic                  aborted;
`ifdef JOHNSON_PHASE_SCHED_HOLD_EN
  logic                  hold;

  modport master (
    output req, len, hold,
    input  grant, phase, phase_valid, busy, done, done_id, aborted
  );

  modport slave (
    input  req, len, hold,
    output grant, phase, phase_valid, busy, done, done_id, aborted
  );
`else
  modport master (
    output req, len,
    input  grant, phase, phase_valid, busy, done, done_id, aborted
  );

  modport slave (
    input  req, len,
    output grant, phase, phase_valid, busy, done, done_id, aborted
  );
`endif

endinterface

// File: rtl/johnson_phase_sched_gen.sv
// johnson_phase_gen
//   WIDTH-bit Johnson counter. clear has priority and loads zero;
//   enable advances one step per clock.
//   clk, rst (async, active-high), clear, enable -> phase[WIDTH]
module johnson_phase_gen
  import johnson_phase_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] phase
);

  logic [WIDTH-1:0] phase_q;
  logic [WIDTH-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (enable) begin
      phase_d = WIDTH'(johnson_next(32'(phase_q), WIDTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/johnson_phase_sched.sv
// johnson_phase_sched
//   Round-robin scheduler sharing one Johnson phase generator among NREQ
//   requesters. A winner gets a burst of len[winner] phases, one per cycle,
//   then done pulses for one cycle and arbitration resumes.
//   Ports: clk, rst (async, active-high), bus (johnson_phase_sched_if.slave)
//   Optional: define JOHNSON_PHASE_SCHED_HOLD_EN to enable bus.hold, which
//   freezes phase and remaining count during RUN (phase_valid drops).
module johnson_phase_sched
  import johnson_phase_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  johnson_phase_sched_if.slave  bus
);

  localparam int unsigned ID_W = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   last_owner_q, last_owner_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              pv_q, pv_d;
  logic              done_q, done_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic              aborted_q, aborted_d;

  logic              gen_clear;
  logic              gen_en;
  logic [WIDTH-1:0]  gen_phase;

  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic [LEN_W-1:0]  len_arr [NREQ];
  logic [LEN_W-1:0]  win_len;
  logic              hold_in;

`ifdef JOHNSON_PHASE_SCHED_HOLD_EN
  assign hold_in = bus.hold;
`else
  assign hold_in = 1'b0;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr[g] = bus.len[g*LEN_W +: LEN_W];
  end

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = ID_W'((32'(last_owner_q) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign win_len = len_arr[winner];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rem_d        = rem_q;
    pv_d         = 1'b0;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    aborted_d    = 1'b0;
    gen_clear    = 1'b0;
    gen_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d   = winner;
          rem_d     = win_len;
          gen_clear = 1'b1;
          if (win_len == '0) begin
            // Empty burst: straight to DONE, never presents a phase.
            state_d   = DONE;
            grant_d   = '0;
            done_d    = 1'b1;
            done_id_d = winner;
          end else begin
            state_d = RUN;
            grant_d = NREQ'(1) << winner;
            pv_d    = 1'b1;
          end
        end
      end

      RUN: begin
        // Outputs are registered, so DONE-state values are loaded on entry.
        if (!bus.req[owner_q]) begin
          state_d   = DONE;
          grant_d   = '0;
          done_d    = 1'b1;
          done_id_d = owner_q;
          aborted_d = 1'b1;
        end else if (hold_in) begin
          pv_d = 1'b0;
        end else if (rem_q == LEN_W'(1)) begin
          state_d   = DONE;
          grant_d   = '0;
          done_d    = 1'b1;
          done_id_d = owner_q;
        end else begin
          gen_en = 1'b1;
          rem_d  = rem_q - LEN_W'(1);
          pv_d   = 1'b1;
        end
      end

      DONE: begin
        state_d      = IDLE;
        last_owner_d = owner_q;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= ID_W'(NREQ - 1);
      rem_q        <= '0;
      pv_q         <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= '0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rem_q        <= rem_d;
      pv_q         <= pv_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      aborted_q    <= aborted_d;
    end
  end

  johnson_phase_gen #(
    .WIDTH (WIDTH)
  ) u_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (gen_clear),
    .enable (gen_en),
    .phase  (gen_phase)
  );

  assign bus.grant       = grant_q;
  assign bus.phase       = gen_phase;
  assign bus.phase_valid = pv_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.done_id     = done_id_q;
  assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_johnson_phase_sched.sv
module tb_johnson_phase_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int LEN_W = 8;
  localparam int ID_W  = $clog2(NREQ);

  logic clk;
  logic rst;

  johnson_phase_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  johnson_phase_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef JOHNSON_PHASE_SCHED_HOLD_EN
  initial bus.hold = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: pointer of the previous owner.
  int m_last;

  // Observation record of one burst.
  logic [WIDTH-1:0] obs_ph [0:63];
  int               obs_nvalid;
  int               obs_ncyc;
  logic [NREQ-1:0]  obs_grant_first;
  int               obs_grant_bad;
  logic [NREQ-1:0]  obs_grant_at_done;
  logic [ID_W-1:0]  obs_done_id;
  logic             obs_aborted;
  logic             obs_done_after;
  logic             obs_busy_after;
  bit               obs_timeout;

  // Johnson code for phase number j: first WIDTH phases fill ones from the
  // top, the next WIDTH phases drain them from the top.
  function automatic logic [WIDTH-1:0] jmodel(input int j);
    int p;
    int v;
    p = j % (2 * WIDTH);
    if (p < WIDTH) v = ((1 << p) - 1) << (WIDTH - p);
    else           v = (1 << (2 * WIDTH - p)) - 1;
    return WIDTH'(v);
  endfunction

  function automatic int m_pick(input logic [NREQ-1:0] r);
    int w;
    w = -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (w < 0 && r[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
    end
    return w;
  endfunction

  task automatic set_len(input int i, input int v);
    bus.len[i*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  // Watches one burst starting from a request driven at the current negedge.
  task automatic observe(input int drop_after, input int drop_id);
    bit seen;
    seen = 0;
    obs_nvalid = 0; obs_ncyc = 0; obs_grant_bad = 0; obs_timeout = 0;
    obs_grant_first = '0; obs_grant_at_done = '0;
    for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) obs_grant_first = bus.grant;
      if (bus.phase_valid) begin
        if (obs_nvalid < 64) obs_ph[obs_nvalid] = bus.phase;
        if (bus.grant !== obs_grant_first) obs_grant_bad++;
        obs_nvalid++;
        if (drop_after > 0 && obs_nvalid == drop_after) bus.req[drop_id] = 1'b0;
      end
      if (bus.done) begin
        seen = 1;
        obs_ncyc = cyc;
        obs_done_id = bus.done_id;
        obs_aborted = bus.aborted;
        obs_grant_at_done = bus.grant;
      end
    end
    if (!seen) begin
      obs_timeout = 1;
    end else begin
      @(negedge clk);
      obs_done_after = bus.done;
      obs_busy_after = bus.busy;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req = '0;
    bus.len = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.grant, bus.phase, bus.phase_valid, bus.busy, bus.done, bus.done_id, bus.aborted} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got grant=%b phase=%b pv=%b busy=%b done=%b id=%0d ab=%b, want all 0",
               bus.grant, bus.phase, bus.phase_valid, bus.busy, bus.done, bus.done_id, bus.aborted);
    end
    rst = 1'b0;
    m_last = NREQ - 1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.grant !== '0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b grant=%b, want 0/0", bus.busy, bus.grant);
    end
  endtask

  task automatic test_single;
    int perr;
    set_len(0, 8);
    bus.req = 4'b0001;
    observe(0, 0);
    bus.req = '0;
    perr = 0;
    for (int j = 0; j < 8; j++) if (obs_ph[j] !== jmodel(j)) perr++;
    total++;
    if (obs_timeout || obs_grant_first !== 4'b0001 || obs_nvalid != 8 || obs_ncyc != 9) begin
      bad++;
      $display("FAIL single_timing: to=%0d grant=%b nvalid=%0d done_cyc=%0d, want grant=0001 nvalid=8 done_cyc=9",
               obs_timeout, obs_grant_first, obs_nvalid, obs_ncyc);
    end
    total++;
    if (perr != 0) begin
      bad++;
      $display("FAIL single_phases: %0d wrong, first got %b want %b", perr, obs_ph[0], jmodel(0));
    end
    total++;
    if (obs_done_id !== 2'd0 || obs_aborted !== 1'b0 || obs_grant_at_done !== '0) begin
      bad++;
      $display("FAIL single_done: id=%0d ab=%b grant=%b, want 0/0/0000", obs_done_id, obs_aborted, obs_grant_at_done);
    end
    total++;
    if (obs_done_after !== 1'b0 || obs_busy_after !== 1'b0) begin
      bad++;
      $display("FAIL single_after: done=%b busy=%b, want 0/0", obs_done_after, obs_busy_after);
    end
    m_last = 0;
  endtask

  task automatic test_back_to_back;
    logic [NREQ-1:0] expg;
    int w;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    bus.req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      w = m_pick(4'b1111);
      expg = NREQ'(1) << w;
      observe(0, 0);
      if (b == 4) bus.req = '0;
      total++;
      if (obs_timeout || obs_grant_first !== expg || obs_nvalid != 2 || obs_ph[0] !== 4'b0000 ||
          obs_ph[1] !== 4'b1000 || obs_ncyc != 3 || obs_done_id !== ID_W'(w)) begin
        bad++;
        $display("FAIL rr_burst%0d: grant=%b nvalid=%0d ph=%b,%b cyc=%0d id=%0d, want grant=%b 2 0000,1000 3 %0d",
                 b, obs_grant_first, obs_nvalid, obs_ph[0], obs_ph[1], obs_ncyc, obs_done_id, expg, w);
      end
      m_last = w;
    end
  endtask

  task automatic test_wrap;
    int perr;
    set_len(0, 10);
    bus.req = 4'b0001;
    observe(0, 0);
    bus.req = '0;
    perr = 0;
    for (int j = 0; j < 10; j++) if (obs_ph[j] !== jmodel(j)) perr++;
    total++;
    if (obs_timeout || obs_nvalid != 10 || obs_ncyc != 11 || perr != 0 ||
        obs_ph[8] !== 4'b0000 || obs_ph[9] !== 4'b1000) begin
      bad++;
      $display("FAIL wrap: nvalid=%0d cyc=%0d perr=%0d ph8=%b ph9=%b, want 10 11 0 0000 1000",
               obs_nvalid, obs_ncyc, perr, obs_ph[8], obs_ph[9]);
    end
    m_last = 0;
  endtask

  task automatic test_abort;
    set_len(1, 5);
    bus.req = 4'b0010;
    observe(3, 1);
    bus.req = '0;
    total++;
    if (obs_timeout || obs_grant_first !== 4'b0010 || obs_nvalid != 3 || obs_ncyc != 4 ||
        obs_done_id !== 2'd1 || obs_aborted !== 1'b1) begin
      bad++;
      $display("FAIL abort: grant=%b nvalid=%0d cyc=%0d id=%0d ab=%b, want 0010 3 4 1 1",
               obs_grant_first, obs_nvalid, obs_ncyc, obs_done_id, obs_aborted);
    end
    m_last = 1;
  endtask

  task automatic test_zero_len;
    set_len(2, 0);
    bus.req = 4'b0100;
    observe(0, 0);
    bus.req = '0;
    total++;
    if (obs_timeout || obs_nvalid != 0 || obs_ncyc != 1 || obs_done_id !== 2'd2 ||
        obs_aborted !== 1'b0 || obs_busy_after !== 1'b0) begin
      bad++;
      $display("FAIL zero_len: nvalid=%0d cyc=%0d id=%0d ab=%b busy_after=%b, want 0 1 2 0 0",
               obs_nvalid, obs_ncyc, obs_done_id, obs_aborted, obs_busy_after);
    end
    m_last = 2;
  endtask

  task automatic test_reset_mid;
    set_len(0, 8);
    bus.req = 4'b0001;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.grant, bus.phase, bus.phase_valid, bus.busy, bus.done, bus.aborted} !== '0) begin
      bad++;
      $display("FAIL reset_mid_async: grant=%b phase=%b pv=%b busy=%b done=%b ab=%b, want all 0",
               bus.grant, bus.phase, bus.phase_valid, bus.busy, bus.done, bus.aborted);
    end
    bus.req = '0;
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_nodone: done=%b, want 0", bus.done);
    end
    rst = 1'b0;
    m_last = NREQ - 1;
    set_len(0, 2);
    set_len(1, 2);
    bus.req = 4'b0011;
    observe(0, 0);
    bus.req = '0;
    total++;
    if (obs_timeout || obs_grant_first !== 4'b0001 || obs_done_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_ptr: grant=%b id=%0d, want 0001 0", obs_grant_first, obs_done_id);
    end
    m_last = 0;
  endtask

  task automatic test_random;
    logic [NREQ-1:0] mask;
    int lens [NREQ];
    int w, L, drop, expn, perr, errs;
    errs = 0;
    for (int it = 0; it < 40; it++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        lens[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
        set_len(i, lens[i]);
      end
      w = m_pick(mask);
      L = lens[w];
      drop = (L >= 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, L - 1)) : 0;
      expn = (drop > 0) ? drop : L;
      bus.req = mask;
      observe(drop, w);
      perr = 0;
      for (int j = 0; j < expn && j < 64; j++) if (obs_ph[j] !== jmodel(j)) perr++;
      total++;
      if (obs_timeout || obs_nvalid != expn || obs_ncyc != expn + 1 || perr != 0 ||
          obs_done_id !== ID_W'(w) || obs_aborted !== (drop > 0) || obs_grant_bad != 0 ||
          (L > 0 && obs_grant_first !== (NREQ'(1) << w))) begin
        bad++;
        errs++;
        if (errs <= 5)
          $display("FAIL random%0d: mask=%b nvalid=%0d cyc=%0d perr=%0d id=%0d ab=%b grant=%b, want owner=%0d L=%0d nvalid=%0d ab=%0d",
                   it, mask, obs_nvalid, obs_ncyc, perr, obs_done_id, obs_aborted, obs_grant_first,
                   w, L, expn, drop > 0);
      end
      m_last = w;
    end
    bus.req = '0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.len = '0;
    m_last = NREQ - 1;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_abort();
    test_zero_len();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
